// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RV32M funct3 group.
// Fixed latency: WIDTH iterations, then one cycle of sign fix-up and result selection.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               state;
  state_t               state_next;
  logic [2:0]           op_q;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     count;

  logic                 accept;
  logic                 neg_a_in;
  logic                 neg_b_in;
  logic [WIDTH-1:0]     mag_a_in;
  logic [WIDTH-1:0]     mag_b_in;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     fin_result;

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    accept     = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        state_next = CALC;
        accept     = 1'b1;
      end
      CALC: begin
        if (abort)                     state_next = IDLE;
        else if (count == CNT_W'(1))   state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    neg_a_in = a[WIDTH-1] &&
               (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    neg_b_in = b[WIDTH-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
    mag_a_in = neg_a_in ? -a : a;
    mag_b_in = neg_b_in ? -b : b;
  end

  // One shared 2*WIDTH register: multiply keeps {partial, multiplier} and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  always_comb begin
    addend    = acc[0] ? mag_a : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag_b};
    if (op_q[2]) begin
      if (div_diff[WIDTH]) step = {acc[2*WIDTH-2:0], 1'b0};
      else                 step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Quotient for a zero divisor is forced; the remainder path already yields a.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    if (mag_b == '0)           quo_fix = '1;
    else if (sign_a ^ sign_b)  quo_fix = -acc[WIDTH-1:0];
    else                       quo_fix = acc[WIDTH-1:0];
    rem_fix = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                       fin_result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fin_result = quo_fix;
      OP_REM, OP_REMU:              fin_result = rem_fix;
      default:                      fin_result = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      count  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q   <= op;
          sign_a <= neg_a_in;
          sign_b <= neg_b_in;
          mag_a  <= mag_a_in;
          mag_b  <= mag_b_in;
          acc    <= {{WIDTH{1'b0}}, (op[2] ? mag_a_in : mag_b_in)};
          count  <= CNT_W'(WIDTH);
        end
        CALC: if (!abort) begin
          acc   <= step;
          count <= count - CNT_W'(1);
        end
        FIN: if (!abort) begin
          result <= fin_result;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit (WIDTH=32 and WIDTH=8 instances)
// against an arithmetic reference model of the RV32M operations.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start32, abort32, start8, abort8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        busy32, done32, busy8, done8;
  logic [31:0] result32;
  logic [7:0]  result8;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .abort(abort32), .op(op32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .result(result32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .abort(abort8), .op(op8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(result8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on w-bit operands.
  function automatic logic [31:0] model(input int w, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    logic [31:0]     m32  = 32'(mask);
    longint unsigned au   = 64'(a) & mask;
    longint unsigned bu   = 64'(b) & mask;
    longint          as_  = a[w-1] ? longint'(au) - (longint'(1) << w) : longint'(au);
    longint          bs   = b[w-1] ? longint'(bu) - (longint'(1) << w) : longint'(bu);
    logic            ovf  = (as_ == -(longint'(1) << (w - 1))) && (bs == -1);
    longint          ps;
    longint unsigned pu;
    logic [31:0]     r;
    case (op)
      3'd0: begin ps = as_ * bs;           r = 32'(ps) & m32; end
      3'd1: begin ps = as_ * bs;           r = 32'(ps >>> w) & m32; end
      3'd2: begin ps = as_ * longint'(bu); r = 32'(ps >>> w) & m32; end
      3'd3: begin pu = au * bu;            r = 32'(pu >> w) & m32; end
      3'd4: r = (bu == 0) ? m32 : ovf ? 32'(au) : 32'(as_ / bs) & m32;
      3'd5: r = (bu == 0) ? m32 : 32'(au / bu);
      3'd6: r = (bu == 0) ? 32'(au) : ovf ? 32'd0 : 32'(as_ % bs) & m32;
      default: r = (bu == 0) ? 32'(au) : 32'(au % bu);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      3:       return 32'($urandom_range(1, 9));
      default: return $urandom & m;
    endcase
  endfunction

  // Call at a negedge; returns at the negedge after the start cycle.
  task automatic issue(input int w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (w == 8) begin
      op8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end else begin
      op32 = op; a32 = a; b32 = b; start32 = 1'b1;
    end
    @(negedge clock);
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic wait_done(input int w, input int g1, input int g2,
                           output int lat, output logic ok);
    lat = 1;
    while (!((w == 8) ? done8 : done32) && lat < 200) begin
      if (lat == g1 || lat == g2) begin
        start32 = 1'b1; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
      end
      @(negedge clock);
      start32 = 1'b0;
      lat++;
    end
    ok = (w == 8) ? done8 : done32;
  endtask

  task automatic run_check(input int w, input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int g1, input int g2);
    int   lat;
    logic ok;
    issue(w, op, a, b);
    wait_done(w, g1, g2, lat, ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(w + 2));
    check({tag, "_busy"}, 32'((w == 8) ? busy8 : busy32), 32'd0);
    check(tag, (w == 8) ? {24'd0, result8} : result32, exp);
  endtask

  logic [2:0]  d_op[12]  = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6,
                             3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a[12]   = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[12]   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2,
                             32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp[12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start32 = 1'b0; abort32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; abort8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_result", result32, 32'd0);
    check("rst_busy", 32'(busy32), 32'd0);
    check("rst_done", 32'(done32), 32'd0);
    check("rst8_result", {24'd0, result8}, 32'd0);

    // Directed list, each op issued in the done cycle of the previous one.
    for (int i = 0; i < 12; i++)
      run_check(32, $sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], d_exp[i],
                (i == 0) ? 5 : 0, (i == 0) ? 20 : 0);
    @(negedge clock);
    check("done_pulse", 32'(done32), 32'd0);

    run_check(32, "divu_prior", 3'd5, 32'd100, 32'd7, 32'd14, 0, 0);
    issue(32, 3'd0, $urandom, $urandom);
    repeat (9) @(negedge clock);
    abort32 = 1'b1;
    @(negedge clock);
    abort32 = 1'b0;
    check("abort_busy", 32'(busy32), 32'd0);
    check("abort_done", 32'(done32), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done32) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_result", result32, 32'd14);

    issue(32, 3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_result", result32, 32'd0);
    check("midrst_busy", 32'(busy32), 32'd0);
    check("midrst_done", 32'(done32), 32'd0);
    run_check(32, "post_reset", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7)); ra = rnd(32); rb = rnd(32);
      run_check(32, $sformatf("rnd32_op%0d_%h_%h", rop, ra, rb), rop, ra, rb,
                model(32, rop, ra, rb), 0, 0);
    end

    run_check(8, "w8_mulhu", 3'd3, 32'hFF, 32'hFF, 32'hFE, 0, 0);
    run_check(8, "w8_div_ovf", 3'd4, 32'h80, 32'hFF, 32'h80, 0, 0);
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7)); ra = rnd(8); rb = rnd(8);
      run_check(8, $sformatf("rnd8_op%0d_%h_%h", rop, ra, rb), rop, ra, rb,
                model(8, rop, ra, rb), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide execute unit for the multicycle core; implements all eight RV32M operations (RV64-style widths via WIDTH).
- Sits beside the combinational ALU: operands come from the A/B registers, op is funct3, and the result feeds the Result mux.
- The core's control FSM holds in an execute-wait state until done pulses.
- Radix-2, one bit per cycle, fixed latency.

Parameters:
- WIDTH, 32, operand/result width in bits; even, >= 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- abort  input  1  cancel current operation (control-FSM flush)
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  WIDTH  rs1 operand; captured on the accepting edge
- b  input  WIDTH  rs2 operand; captured on the accepting edge
- busy  output  1  high in CALC and FIN
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  registered result; held until the next done

Behaviour:
- Interface: one clock (clock); reset is synchronous, active-high (reset).
- Reset (any state, including mid-operation): state=IDLE; busy=0, done=0, result=0; counter and internal accumulators cleared.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 and abort=0 at edge k → CALC.
  - At that edge, latch op, a and b; convert signed operands to magnitude and record sign flags. Signedness:
    - MULH: both operands signed.
    - MULHSU: a signed, b unsigned.
    - DIV/REM: both signed.
    - Others: unsigned.
  - Load counter = WIDTH.
- CALC: one iteration per edge; counter decrements; when counter reaches 0 → FIN.
  - Multiply: shift-add over a 2*WIDTH product register.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FIN (one edge):
  - Apply sign correction.
  - Multiply: negate the 2*WIDTH product if the operand signs differ (signed ops only).
  - Divide: quotient sign = sign(a) XOR sign(b); remainder takes sign(a).
  - Select result:
    - MUL: low WIDTH bits.
    - MULH/MULHSU/MULHU: high WIDTH bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register result, set done=1, → IDLE.
- Latency: start accepted at edge k → done=1 and result valid in the cycle after edge k+WIDTH+1, for every op and operand value (no early-out).
- done is high for exactly one cycle. result is stable from the done cycle until the next FIN edge.
- start while busy=1: ignored; no queuing; the in-flight op and latched operands are unchanged.
- start in the same cycle done=1 (state already IDLE): accepted. Back-to-back throughput is one op per WIDTH+2 cycles.
- abort=1 in CALC or FIN: → IDLE at the next edge; no done; result keeps its previous value.
- abort=1 in IDLE: overrides start; nothing accepted.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = a (REM and REMU). No exception.
- Signed overflow (a = most negative, b = -1): DIV result = a; REM result = 0.
- Arithmetic: all results are modulo 2^WIDTH; no flags produced.

Test Plan:
- Multiply, WIDTH=32:
  - MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB.
  - MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
  - MULH a=b=0x80000000 → 0x40000000.
  - MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
  - done exactly 34 cycles after the start cycle.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Corner divides:
  - DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - All with the same 34-cycle latency.
- Handshake:
  - Pulse start with new operands at cycles 5 and 20 of an op: ignored, first result unchanged.
  - start in the done cycle: second op accepted, done again 34 cycles later.
  - busy deasserts in the done cycle.
- Abort/reset:
  - abort at iteration 10 → busy=0 next cycle, no done, result retains the prior value 14.
  - reset mid-CALC → result=0, busy=0, done=0; a new op afterwards completes correctly.
- WIDTH=8 instance: MULHU 0xFF*0xFF → 0xFE; DIV 0x80/0xFF → 0x80; latency 10 cycles.
